// File: rtl/edge_det_pkg.sv
// Shared constants and types for the multi-channel edge detector.
// Mode encodings, the per-channel level FSM states and the edge-qualify helper live here.
package edge_det_pkg;

   localparam logic [1:0] MODE_OFF  = 2'b00;
   localparam logic [1:0] MODE_RISE = 2'b01;
   localparam logic [1:0] MODE_FALL = 2'b10;
   localparam logic [1:0] MODE_BOTH = 2'b11;

   typedef enum logic {
      ST_LOW  = 1'b0,
      ST_HIGH = 1'b1
   } fsm_state_e;

   // True when a filtered transition of the given direction is enabled by mode.
   function automatic logic edge_enabled(input logic [1:0] mode,
                                         input logic       rise,
                                         input logic       fall);
      logic hit;
      hit = 1'b0;
      case (mode)
         MODE_OFF:  hit = 1'b0;
         MODE_RISE: hit = rise;
         MODE_FALL: hit = fall;
         MODE_BOTH: hit = rise | fall;
         default:   hit = 1'b0;
      endcase
      return hit;
   endfunction

endpackage

// File: rtl/edge_det_channel.sv
// One detector channel: synchroniser chain, stability filter, LOW/HIGH level FSM,
// registered tick and sticky write-1-to-clear pend flag.
module edge_det_channel
   import edge_det_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       level,
   input  logic [1:0] mode,
   input  logic       clr,
   output logic       tick,
   output logic       pend,
   output fsm_state_e state
);

   localparam int CNT_W = $clog2(FILTER_LEN + 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s;
   logic [CNT_W-1:0]       cnt_q;
   logic [CNT_W-1:0]       cnt_d;
   fsm_state_e             state_q;
   fsm_state_e             state_d;
   logic                   tick_q;
   logic                   tick_set;
   logic                   pend_q;

   assign s = sync_q[SYNC_STAGES-1];

   // The filtered level is the FSM state; a toggle happens only once the
   // synchronised input has disagreed for FILTER_LEN consecutive samples.
   always_comb begin
      state_d  = state_q;
      cnt_d    = '0;
      tick_set = 1'b0;
      if (s != (state_q == ST_HIGH)) begin
         if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
            state_d  = (state_q == ST_LOW) ? ST_HIGH : ST_LOW;
            tick_set = edge_enabled(mode, state_q == ST_LOW, state_q == ST_HIGH);
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q  <= '0;
         cnt_q   <= '0;
         state_q <= ST_LOW;
         tick_q  <= 1'b0;
         pend_q  <= 1'b0;
      end else begin
         sync_q[0] <= level;
         for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_q[k] <= sync_q[k-1];
         end
         cnt_q   <= cnt_d;
         state_q <= state_d;
         tick_q  <= tick_set;
         // A new qualified edge beats a clear strobe in the same cycle.
         pend_q  <= tick_set | (pend_q & ~clr);
      end
   end

   assign tick  = tick_q;
   assign pend  = pend_q;
   assign state = state_q;

endmodule

// File: rtl/multi_edge_detector.sv
// N_CH independent filtered edge-detector channels with a combined interrupt line.
// filt is taken straight from each channel's LOW/HIGH state register.
module multi_edge_detector
   import edge_det_pkg::*;
#(
   parameter int N_CH        = 8,
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [N_CH-1:0]   level,
   input  logic [2*N_CH-1:0] mode,
   input  logic [N_CH-1:0]   clr,
   output logic [N_CH-1:0]   tick,
   output logic [N_CH-1:0]   pend,
   output logic [N_CH-1:0]   filt,
   output logic              irq
);

   fsm_state_e ch_state [N_CH];

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      edge_det_channel #(
         .SYNC_STAGES (SYNC_STAGES),
         .FILTER_LEN  (FILTER_LEN)
      ) u_ch (
         .clk   (clk),
         .reset (reset),
         .level (level[i]),
         .mode  (mode[2*i+1:2*i]),
         .clr   (clr[i]),
         .tick  (tick[i]),
         .pend  (pend[i]),
         .state (ch_state[i])
      );

      assign filt[i] = (ch_state[i] == ST_HIGH);
   end

   assign irq = |pend;

endmodule
